// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the hard-wired zero register number.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator: the load in EX writes a register that the
// instruction in ID is about to read.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_reg,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    // $0 is never a real dependency, and rt only matters when ID reads it
    always_comb begin
        load_use = ex_mem_read && (ex_write_reg != REG_ZERO) &&
                   ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, memory-wait freeze with timeout, and saturating performance counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             BranchTaken,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Write,
    output logic             MEMWB_Write,
    output logic             MEMWB_Bubble,
    output logic             MemError,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int               TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    logic              mem_error_q, mem_error_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;
    logic              mem_acc_s;
    logic              load_use_s;
    logic              freeze_s;

    hazard_detect u_hazard_detect (
        .ex_mem_read  (EX_MemRead),
        .ex_write_reg (EX_WriteReg),
        .id_rs        (ID_Rs),
        .id_rt        (ID_Rt),
        .id_uses_rt   (ID_UsesRt),
        .load_use     (load_use_s)
    );

    // Next-state, timeout and pipeline control outputs
    always_comb begin
        mem_acc_s    = MEM_MemRead | MEM_MemWrite;
        state_d      = state_q;
        timeout_d    = timeout_q;
        mem_error_d  = mem_error_q;
        freeze_s     = 1'b0;
        MemReq       = 1'b0;
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Write  = 1'b1;
        MEMWB_Write  = 1'b1;
        MEMWB_Bubble = 1'b0;

        if (Reset) begin
            state_d      = RUN;
            timeout_d    = {TO_W{1'b0}};
            mem_error_d  = 1'b0;
            PCWrite      = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            MEMWB_Bubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    MemReq = mem_acc_s;
                    if (mem_acc_s && !MemReady) begin
                        freeze_s  = 1'b1;
                        state_d   = MEM_WAIT;
                        timeout_d = TO_W'(1);
                    end else if (load_use_s) begin
                        // A taken branch is dropped here; ID re-resolves it next cycle
                        PCWrite    = 1'b0;
                        IFID_Write = 1'b0;
                        IDEX_Flush = 1'b1;
                    end else begin
                        IFID_Flush = ID_Branch & BranchTaken;
                    end
                end
                MEM_WAIT: begin
                    MemReq = mem_acc_s;
                    if (MemReady) begin
                        state_d   = RUN;
                        timeout_d = {TO_W{1'b0}};
                    end else if (timeout_q == TO_LAST) begin
                        freeze_s    = 1'b1;
                        mem_error_d = 1'b1;
                        state_d     = ERROR;
                    end else begin
                        freeze_s  = 1'b1;
                        timeout_d = timeout_q + TO_W'(1);
                    end
                end
                ERROR: begin
                    PCWrite      = 1'b0;
                    IFID_Write   = 1'b0;
                    EXMEM_Write  = 1'b0;
                    MEMWB_Write  = 1'b0;
                    MEMWB_Bubble = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Memory freeze holds the front of the pipe and drains bubbles into WB
        if (freeze_s) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end else begin
            MEMWB_Bubble = MEMWB_Bubble;
        end
    end

    // Saturating performance counters, idle while in reset
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (Reset) begin
            stall_count_d = {CNT_W{1'b0}};
            flush_count_d = {CNT_W{1'b0}};
        end else begin
            if (!PCWrite && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end else begin
                stall_count_d = stall_count_q;
            end
            if (IFID_Flush && (flush_count_q != CNT_MAX)) begin
                flush_count_d = flush_count_q + CNT_W'(1);
            end else begin
                flush_count_d = flush_count_q;
            end
        end
    end

    // State and counter registers (reset values arrive through the _d logic)
    always_ff @(posedge Clk) begin
        state_q       <= state_d;
        timeout_q     <= timeout_d;
        mem_error_q   <= mem_error_d;
        stall_count_q <= stall_count_d;
        flush_count_q <= flush_count_d;
    end

    assign MemError   = mem_error_q;
    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;

endmodule
